burst_ram_responder: RTL and testbench
======================================

Name: burst_ram_responder

Overview:
- Behavioural/synthesizable model of the PSRAM burst-RAM IP. It is the responder end of the `br_*` burst interface that the cache drives.
- Holds a 64-bit-word memory. It accepts one read or write command per command interval and moves fixed bursts of 4 x 64-bit words.
- Used as the RAM behind the cache in simulation benches and in FPGA builds without PSRAM. It also flags initiator protocol violations.

Parameters:
- BURST_RAM_DEPTH_BITWIDTH, 21, width of `br_addr` (address unit is one 64-bit word).
- MEMORY_DEPTH_BITWIDTH, 12, implemented words = 2^value; higher address bits are ignored (aliasing).
- READ_LATENCY, 6, cycles from the `br_cmd_en` edge to the first read beat; legal range 2..10.
- COMMAND_INTERVAL, 14, minimum cycles between two accepted `br_cmd_en` edges.
- CALIB_CYCLES, 16, cycles after reset release before `init_calib` rises.
- MASK_ENABLE, 0, 1: honour `br_data_mask`; 0: ignore the mask and write all bytes.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- br_cmd  in  1  0: read, 1: write; sampled with `br_cmd_en`
- br_cmd_en  in  1  command valid for one cycle
- br_addr  in  BURST_RAM_DEPTH_BITWIDTH  burst start word address; sampled with `br_cmd_en`
- br_wr_data  in  64  write beat data
- br_data_mask  in  8  per-byte mask, 1 = byte not written (only when MASK_ENABLE=1)
- br_rd_data  out  64  read beat data
- br_rd_data_valid  out  1  read beat valid
- init_calib  out  1  high when ready for commands
- busy  out  1  high while a command or its interval is in progress
- protocol_error  out  1  sticky violation flag, cleared only by `rst`

Behaviour:
- **Reset.** `rst` asserted immediately forces all outputs to 0 and the state to CALIB, aborting any burst in flight. Memory contents are NOT reset.
- **CALIB.** Counts CALIB_CYCLES, then raises `init_calib` and goes to IDLE. `init_calib` stays 1 until the next reset.
- **Command acceptance (IDLE).** `br_cmd_en`=1 at edge T is accepted.
  - Latch `br_cmd`, `base = br_addr[1:0]`, `line = br_addr[MEMORY_DEPTH_BITWIDTH-1:2]`.
  - Load the interval counter with COMMAND_INTERVAL-1 and raise `busy` from T+1.
- **Burst addressing.** Beat i (0..3) uses word `{line, (base+i) mod 4}`. The burst wraps inside the aligned 4-word block.
- **Write burst.**
  - Beat 0 = `br_wr_data` at edge T, written at T.
  - Beats 1..3 = `br_wr_data` at edges T+1, T+2, T+3, written at those edges. `br_cmd_en` is not required on these edges.
  - State WRITE counts beats, then RECOVER.
- **Read burst.**
  - State READ_WAIT counts READ_LATENCY-1 cycles.
  - READ_BURST then drives `br_rd_data_valid`=1 on exactly 4 consecutive cycles, T+READ_LATENCY .. T+READ_LATENCY+3, with beats 0..3 in order. Then RECOVER.
  - `br_rd_data`=0 whenever `br_rd_data_valid`=0.
- **RECOVER.** Waits until the interval counter reaches 0, then IDLE with `busy`=0. The earliest next accepted command is at T+COMMAND_INTERVAL.
- **Interval counter.** Decrements every cycle independently of state. Requirement: READ_LATENCY+4 <= COMMAND_INTERVAL (elaboration check).
- **Read-after-write.** A read at T+COMMAND_INTERVAL after a write returns the newly written data. Write-then-read of the same word never returns stale data.
- **Mask.** With MASK_ENABLE=1, each byte is written only where its mask bit is 0, on every beat.
- **Violations.** Each of the following sets `protocol_error` and is otherwise ignored (no memory change, no read beats):
  - `br_cmd_en` while `init_calib`=0;
  - `br_cmd_en` while `busy`=1 or outside IDLE;
  - `br_cmd_en` on write beats 1..3.

  An in-progress burst continues unaffected.
- **Simultaneous events.** `rst` overrides everything. A `br_cmd_en` on the cycle the interval counter reaches 0 and the state returns to IDLE is accepted only if the state is already IDLE at that edge; otherwise it is a violation.

Test Plan:
- **Calibration.** Release `rst`, MASK_ENABLE=0 → `init_calib` rises after 16 cycles. `br_cmd_en` at cycle 5 → `protocol_error`=1, no data valid.
- **Write then read.**
  - Write at addr 0x000008 with beats 0x1111..., 0x2222..., 0x3333..., 0x4444... (each 64-bit beat repeats its hex digit).
  - Read the same addr 14 cycles later → `br_rd_data_valid` high for exactly cycles T+6..T+9 with the same 4 beats in order.
- **Wrap.** Read at addr 0x00000A after the above → beats 0x3333..., 0x4444..., 0x1111..., 0x2222....
- **Back-to-back violation.** Read at T, second `br_cmd_en` at T+5 → `protocol_error`=1; first burst still delivers 4 beats; no second burst.
- **Mask.** MASK_ENABLE=1, write addr 0x10 beat 0 data 0xFFFF_FFFF_FFFF_FFFF, mask 0x0F, word previously 0 → read beat 0 = 0xFFFF_FFFF_0000_0000.
- **Reset mid-burst.** `rst` asserted at T+7 of a read → valid drops at once, `init_calib`=0. After recalibration, re-reading previously written data returns it intact.

Source files
------------

// File: rtl/burst_ram_responder.sv
// Responder end of the br_* burst interface: a 64-bit word RAM serving fixed
// 4-beat wrapping bursts, with calibration delay, command spacing and violation flagging.
module burst_ram_responder #(
   parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
   parameter int MEMORY_DEPTH_BITWIDTH    = 12,
   parameter int READ_LATENCY             = 6,
   parameter int COMMAND_INTERVAL         = 14,
   parameter int CALIB_CYCLES             = 16,
   parameter int MASK_ENABLE              = 0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                br_cmd,
   input  logic                                br_cmd_en,
   input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
   input  logic [63:0]                         br_wr_data,
   input  logic [7:0]                          br_data_mask,
   output logic [63:0]                         br_rd_data,
   output logic                                br_rd_data_valid,
   output logic                                init_calib,
   output logic                                busy,
   output logic                                protocol_error
);

   localparam int MEM_WORDS = 2 ** MEMORY_DEPTH_BITWIDTH;
   localparam int LINE_W    = MEMORY_DEPTH_BITWIDTH - 2;
   localparam int INT_W     = $clog2(COMMAND_INTERVAL + 1);
   localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);

   typedef enum logic [2:0] {
      CALIB,
      IDLE,
      WRITE,
      READ_WAIT,
      READ_BURST,
      RECOVER
   } state_t;

   generate
      if (READ_LATENCY < 2 || READ_LATENCY > 10 || READ_LATENCY + 4 > COMMAND_INTERVAL) begin : g_paramCheck
         $error("burst_ram_responder: READ_LATENCY must be 2..10 and READ_LATENCY+4 <= COMMAND_INTERVAL");
      end
   endgenerate

   state_t                            r_state;
   logic [CAL_W-1:0]                  r_calibCnt;
   logic [INT_W-1:0]                  r_interval;
   logic [3:0]                        r_waitCnt;
   logic [LINE_W-1:0]                 r_line;
   logic [1:0]                        r_base;
   logic [1:0]                        r_beat;
   logic [63:0]                       r_mem [0:MEM_WORDS-1];

   logic                              w_accept;
   logic                              w_violation;
   logic                              w_wrEn;
   logic [1:0]                        w_offset;
   logic [MEMORY_DEPTH_BITWIDTH-1:0]  w_burstAddr;
   logic [MEMORY_DEPTH_BITWIDTH-1:0]  w_wrAddr;
   logic [7:0]                        w_byteEn;
   logic                              w_lastInterval;
   logic                              w_unusedAddrBits;

   // Address bits above the implemented depth alias onto the same words.
   assign w_unusedAddrBits = ^br_addr[BURST_RAM_DEPTH_BITWIDTH-1:MEMORY_DEPTH_BITWIDTH];

   assign w_accept       = br_cmd_en && (r_state == IDLE);
   assign w_violation    = br_cmd_en && (r_state != IDLE);
   assign w_offset       = r_base + r_beat;
   assign w_burstAddr    = {r_line, w_offset};
   assign w_wrEn         = (w_accept && br_cmd) || (r_state == WRITE);
   assign w_wrAddr       = (r_state == WRITE) ? w_burstAddr : br_addr[MEMORY_DEPTH_BITWIDTH-1:0];
   assign w_byteEn       = (MASK_ENABLE != 0) ? ~br_data_mask : 8'hFF;
   assign w_lastInterval = (r_interval <= INT_W'(1));

   // Storage has no reset so contents survive recalibration.
   always_ff @(posedge clk) begin
      if (w_wrEn) begin
         for (int b = 0; b < 8; b++) begin
            if (w_byteEn[b]) begin
               r_mem[w_wrAddr][8*b +: 8] <= br_wr_data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= CALIB;
         r_calibCnt       <= '0;
         r_interval       <= '0;
         r_waitCnt        <= '0;
         r_line           <= '0;
         r_base           <= '0;
         r_beat           <= '0;
         br_rd_data       <= '0;
         br_rd_data_valid <= 1'b0;
         init_calib       <= 1'b0;
         busy             <= 1'b0;
         protocol_error   <= 1'b0;
      end else begin
         if (r_interval != '0) begin
            r_interval <= r_interval - 1'b1;
         end
         if (w_violation) begin
            protocol_error <= 1'b1;
         end

         unique case (r_state)
            CALIB: begin
               if (r_calibCnt == CAL_W'(CALIB_CYCLES - 1)) begin
                  init_calib <= 1'b1;
                  r_state    <= IDLE;
               end else begin
                  r_calibCnt <= r_calibCnt + 1'b1;
               end
            end

            IDLE: begin
               if (w_accept) begin
                  r_line     <= br_addr[MEMORY_DEPTH_BITWIDTH-1:2];
                  r_base     <= br_addr[1:0];
                  r_interval <= INT_W'(COMMAND_INTERVAL - 1);
                  busy       <= 1'b1;
                  if (br_cmd) begin
                     r_beat  <= 2'd1;
                     r_state <= WRITE;
                  end else begin
                     r_beat    <= 2'd0;
                     r_waitCnt <= 4'(READ_LATENCY - 2);
                     r_state   <= READ_WAIT;
                  end
               end
            end

            // Beat 0 was written on the accept edge; beats 1..3 follow back to back.
            WRITE: begin
               if (r_beat == 2'd3) begin
                  r_state <= RECOVER;
               end else begin
                  r_beat <= r_beat + 1'b1;
               end
            end

            READ_WAIT: begin
               if (r_waitCnt == 4'd0) begin
                  br_rd_data       <= r_mem[w_burstAddr];
                  br_rd_data_valid <= 1'b1;
                  r_beat           <= r_beat + 1'b1;
                  r_state          <= READ_BURST;
               end else begin
                  r_waitCnt <= r_waitCnt - 1'b1;
               end
            end

            // r_beat wraps to 0 after the fourth beat has been presented.
            READ_BURST: begin
               if (r_beat == 2'd0) begin
                  br_rd_data       <= '0;
                  br_rd_data_valid <= 1'b0;
                  if (w_lastInterval) begin
                     busy    <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_state <= RECOVER;
                  end
               end else begin
                  br_rd_data <= r_mem[w_burstAddr];
                  r_beat     <= r_beat + 1'b1;
               end
            end

            RECOVER: begin
               if (w_lastInterval) begin
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end

            default: begin
               r_state <= CALIB;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_ram_responder.sv
// Bench for burst_ram_responder: a word model predicts read beats and their
// arrival edge; a negedge monitor pops and compares them as the DUT emits beats.
module tb_burst_ram_responder;

   localparam int RL = 6;
   localparam int CI = 14;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br_cmd = 1'b0;
   logic        br_cmd_en = 1'b0;
   logic [20:0] br_addr = '0;
   logic [63:0] br_wr_data = '0;
   logic [7:0]  br_data_mask = '0;
   logic [63:0] br_rd_data;
   logic        br_rd_data_valid;
   logic        init_calib;
   logic        busy;
   logic        protocol_error;

   typedef struct {
      logic [63:0] data;
      int          atEdge;
   } beat_t;

   beat_t       expQ [$];
   beat_t       monBeat;
   logic [63:0] model [int];
   logic [63:0] stimBeats [4];
   logic [7:0]  stimMasks [4];
   int          edgeIdx = 0;
   int          errors = 0;
   int          checks = 0;

   burst_ram_responder #(
      .BURST_RAM_DEPTH_BITWIDTH(21),
      .MEMORY_DEPTH_BITWIDTH(12),
      .READ_LATENCY(RL),
      .COMMAND_INTERVAL(CI),
      .CALIB_CYCLES(16),
      .MASK_ENABLE(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .br_cmd(br_cmd),
      .br_cmd_en(br_cmd_en),
      .br_addr(br_addr),
      .br_wr_data(br_wr_data),
      .br_data_mask(br_data_mask),
      .br_rd_data(br_rd_data),
      .br_rd_data_valid(br_rd_data_valid),
      .init_calib(init_calib),
      .busy(busy),
      .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeIdx <= edgeIdx + 1;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", tag, actual, expected, edgeIdx);
      end
   endtask

   function automatic int wordAddr(input logic [20:0] addr, input int i);
      logic [1:0] off;
      off = addr[1:0] + 2'(i);
      return int'({addr[11:2], off});
   endfunction

   task automatic modelWrite(input int w, input logic [63:0] d, input logic [7:0] m);
      logic [63:0] cur;
      cur = model.exists(w) ? model[w] : 64'd0;
      for (int b = 0; b < 8; b++) begin
         if (!m[b]) cur[8*b +: 8] = d[8*b +: 8];
      end
      model[w] = cur;
   endtask

   task automatic loadBurst(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2,
                            input logic [63:0] b3, input logic [7:0] m0, input logic [7:0] m123);
      stimBeats[0] = b0; stimBeats[1] = b1; stimBeats[2] = b2; stimBeats[3] = b3;
      stimMasks[0] = m0; stimMasks[1] = m123; stimMasks[2] = m123; stimMasks[3] = m123;
   endtask

   // Called at a negedge; issues a command sampled at edge atEdge (or the next edge if later).
   task automatic applyStimulus(input logic isWrite, input logic [20:0] addr, input int atEdge,
                                input logic holdEnBeat2, output int tAccept);
      beat_t b;
      while (edgeIdx + 1 < atEdge) @(negedge clk);
      tAccept      = edgeIdx + 1;
      br_cmd       = isWrite;
      br_cmd_en    = 1'b1;
      br_addr      = addr;
      br_wr_data   = stimBeats[0];
      br_data_mask = stimMasks[0];
      for (int i = 0; i < 4; i++) begin
         if (isWrite) begin
            modelWrite(wordAddr(addr, i), stimBeats[i], stimMasks[i]);
         end else begin
            b.data   = model[wordAddr(addr, i)];
            b.atEdge = tAccept + RL + i;
            expQ.push_back(b);
         end
      end
      @(negedge clk);
      br_cmd_en = 1'b0;
      if (isWrite) begin
         for (int i = 1; i < 4; i++) begin
            br_wr_data   = stimBeats[i];
            br_data_mask = stimMasks[i];
            br_cmd_en    = holdEnBeat2 && (i == 2);
            @(negedge clk);
         end
      end
      br_cmd_en    = 1'b0;
      br_wr_data   = '0;
      br_data_mask = '0;
   endtask

   // A command the DUT must reject: no model update, no expected beats.
   task automatic pulseCmd(input logic isWrite, input logic [20:0] addr, input logic [63:0] d, input int atEdge);
      while (edgeIdx + 1 < atEdge) @(negedge clk);
      br_cmd     = isWrite;
      br_cmd_en  = 1'b1;
      br_addr    = addr;
      br_wr_data = d;
      @(negedge clk);
      br_cmd_en  = 1'b0;
      br_wr_data = '0;
   endtask

   task automatic waitCalib();
      int n;
      n = 0;
      while (!init_calib && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("calibReady", 64'(init_calib), 64'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expQ.size() > 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", 64'(expQ.size()), 64'd0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst       = 1'b1;
      br_cmd_en = 1'b0;
      repeat (2) @(negedge clk);
      expQ.delete();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (br_rd_data_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedBeat", 64'(br_rd_data_valid), 64'd0);
            end else begin
               monBeat = expQ.pop_front();
               checkOutput("rdData", br_rd_data, monBeat.data);
               checkOutput("rdEdge", 64'(edgeIdx + 1), 64'(monBeat.atEdge));
            end
         end else begin
            checkOutput("rdDataIdle", br_rd_data, 64'd0);
            if (expQ.size() > 0 && expQ[0].atEdge <= edgeIdx + 1) begin
               checkOutput("missingBeat", 64'(br_rd_data_valid), 64'd1);
               monBeat = expQ.pop_front();
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int t;
      int tr;

      repeat (3) @(negedge clk);
      checkOutput("rstValid", 64'(br_rd_data_valid), 64'd0);
      checkOutput("rstData", br_rd_data, 64'd0);
      checkOutput("rstCalib", 64'(init_calib), 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstError", 64'(protocol_error), 64'd0);

      // Calibration window and a command issued before it ends.
      rst  = 1'b0;
      base = edgeIdx;
      pulseCmd(1'b0, 21'h0, 64'd0, base + 5);
      checkOutput("errEarlyCmd", 64'(protocol_error), 64'd1);
      while (edgeIdx < base + 15) @(negedge clk);
      checkOutput("calibLow", 64'(init_calib), 64'd0);
      @(negedge clk);
      checkOutput("calibHigh", 64'(init_calib), 64'd1);
      repeat (10) @(negedge clk);

      doReset();
      waitCalib();
      checkOutput("errCleared", 64'(protocol_error), 64'd0);

      // Write then read-after-write, with the busy window checked.
      loadBurst(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 8'h00, 8'h00);
      applyStimulus(1'b1, 21'h000008, edgeIdx + 1, 1'b0, t);
      checkOutput("busyWrite", 64'(busy), 64'd1);
      while (edgeIdx < t + CI - 2) @(negedge clk);
      checkOutput("busyLate", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("busyDone", 64'(busy), 64'd0);
      applyStimulus(1'b0, 21'h000008, t + CI, 1'b0, t);
      applyStimulus(1'b0, 21'h00000A, t + CI, 1'b0, t);
      checkOutput("noErrLegal", 64'(protocol_error), 64'd0);

      // Masked write over a zeroed line.
      loadBurst(64'd0, 64'd0, 64'd0, 64'd0, 8'h00, 8'h00);
      applyStimulus(1'b1, 21'h000010, t + CI, 1'b0, t);
      loadBurst(64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA,
                64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 8'hFF);
      applyStimulus(1'b1, 21'h000010, t + CI, 1'b0, t);
      applyStimulus(1'b0, 21'h000010, t + CI, 1'b0, t);
      drain();

      // Back-to-back command is rejected without touching memory.
      applyStimulus(1'b0, 21'h000008, t + CI, 1'b0, t);
      pulseCmd(1'b1, 21'h000010, 64'hDEAD_BEEF_DEAD_BEEF, t + 5);
      checkOutput("errBackToBack", 64'(protocol_error), 64'd1);
      applyStimulus(1'b0, 21'h000010, t + CI, 1'b0, t);

      // Command on the edge the interval expires is rejected; next edge is legal.
      pulseCmd(1'b0, 21'h000010, 64'd0, t + CI - 1);
      applyStimulus(1'b0, 21'h00000A, t + CI, 1'b0, t);
      drain();

      // Reset in the middle of a read burst.
      applyStimulus(1'b0, 21'h000008, t + CI, 1'b0, tr);
      while (edgeIdx < tr + 7) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midRstValid", 64'(br_rd_data_valid), 64'd0);
      checkOutput("midRstData", br_rd_data, 64'd0);
      checkOutput("midRstCalib", 64'(init_calib), 64'd0);
      checkOutput("midRstBusy", 64'(busy), 64'd0);
      checkOutput("midRstError", 64'(protocol_error), 64'd0);
      expQ.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      waitCalib();
      applyStimulus(1'b0, 21'h000008, edgeIdx + 1, 1'b0, t);
      applyStimulus(1'b0, 21'h000010, t + CI, 1'b0, t);

      // Command during write beat 2 is flagged but the burst completes.
      checkOutput("errBeforeBeat", 64'(protocol_error), 64'd0);
      loadBurst(64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 8'h00, 8'h00);
      applyStimulus(1'b1, 21'h000021, t + CI, 1'b1, t);
      checkOutput("errWriteBeat", 64'(protocol_error), 64'd1);
      applyStimulus(1'b0, 21'h000020, t + CI, 1'b0, t);
      drain();
      repeat (20) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
